// File: rtl/arith_pkg.sv
// Shared encodings for the arithmetic sequencer: issue modes, operation codes,
// sequencer states and default pipeline latencies.
package arith_pkg;

    typedef enum logic [1:0] {
        MODE_EXP_SUM = 2'd0,
        MODE_DIV     = 2'd1,
        MODE_GELU    = 2'd2,
        MODE_AGG     = 2'd3
    } ap_mode_e;

    typedef enum logic [1:0] {
        OP_SOFTMAX = 2'd0,
        OP_GELU    = 2'd1,
        OP_AGG     = 2'd2,
        OP_RSVD    = 2'd3
    } op_type_e;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_EXP       = 3'd1,
        S_EXP_DRAIN = 3'd2,
        S_DIV       = 3'd3,
        S_STREAM    = 3'd4,
        S_DONE      = 3'd5
    } seq_state_e;

    localparam int DEF_ADD_LAT = 3;
    localparam int DEF_MUL_LAT = 3;

endpackage

// File: rtl/arith_sequencer.sv
// Sequences softmax (exp+sum then divide) over a small score buffer and forwards
// GeLU/AGG streams into the arithmetic pipeline issue port.
module arith_sequencer
    import arith_pkg::*;
#(
    parameter int ADD_LAT = DEF_ADD_LAT,
    parameter int MUL_LAT = DEF_MUL_LAT
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        sc_wr_en,
    input  logic [2:0]  sc_wr_idx,
    input  logic [15:0] sc_wr_data,
    input  logic        op_start,
    input  logic [1:0]  op_type,
    input  logic [2:0]  op_km1,
    input  logic [7:0]  op_len,
    input  logic        s_valid,
    output logic        s_ready,
    input  logic [15:0] s_data,
    input  logic [15:0] s_psum,
    output logic        ap_valid,
    output logic [15:0] ap_data,
    output logic [15:0] ap_psum,
    output logic [1:0]  ap_mode,
    output logic        busy,
    output logic        done,
    output logic        err
);

    // Gap counts: beat spacing waits LAT cycles, the post-phase drain waits LAT+1.
    localparam logic [7:0] ADD_GAP = 8'(ADD_LAT);
    localparam logic [7:0] ADD_END = 8'(ADD_LAT + 1);
    localparam logic [7:0] MUL_GAP = 8'(MUL_LAT);
    localparam logic [7:0] MUL_END = 8'(MUL_LAT + 1);

    seq_state_e  state_r, state_s;
    logic [7:0]  sp_r, sp_s;
    logic [7:0]  rem_r, rem_s;
    logic [2:0]  idx_r, idx_s;
    logic [2:0]  k_r, k_s;
    logic [1:0]  smode_r, smode_s;
    logic        ap_valid_r, ap_valid_s;
    logic [15:0] ap_data_r, ap_data_s;
    logic [15:0] ap_psum_r, ap_psum_s;
    logic [1:0]  ap_mode_r, ap_mode_s;
    logic        s_ready_r, s_ready_s;
    logic        busy_r, done_r, err_r, err_s;
    logic [15:0] score_r [8];

    // Next-state and next-output logic for the sequencer.
    always_comb begin
        state_s    = state_r;
        sp_s       = sp_r;
        rem_s      = rem_r;
        idx_s      = idx_r;
        k_s        = k_r;
        smode_s    = smode_r;
        ap_valid_s = 1'b0;
        ap_data_s  = ap_data_r;
        ap_psum_s  = ap_psum_r;
        ap_mode_s  = ap_mode_r;
        s_ready_s  = 1'b0;
        err_s      = 1'b0;
        case (state_r)
            S_IDLE: begin
                if (op_start) begin
                    case (op_type)
                        OP_SOFTMAX: begin
                            k_s        = op_km1;
                            ap_valid_s = 1'b1;
                            ap_data_s  = score_r[0];
                            ap_psum_s  = 16'd0;
                            ap_mode_s  = MODE_EXP_SUM;
                            idx_s      = 3'd1;
                            rem_s      = {5'd0, op_km1};
                            if (op_km1 == 3'd0) begin
                                state_s = S_EXP_DRAIN;
                                sp_s    = ADD_END;
                            end else begin
                                state_s = S_EXP;
                                sp_s    = ADD_GAP;
                            end
                        end
                        OP_GELU: begin
                            state_s   = S_STREAM;
                            rem_s     = op_len;
                            smode_s   = MODE_GELU;
                            s_ready_s = 1'b1;
                        end
                        OP_AGG: begin
                            state_s   = S_STREAM;
                            rem_s     = {5'd0, op_km1} + 8'd1;
                            smode_s   = MODE_AGG;
                            s_ready_s = 1'b1;
                        end
                        default: begin
                            err_s = 1'b1;
                        end
                    endcase
                end else begin
                    state_s = S_IDLE;
                end
            end
            S_EXP: begin
                if (sp_r != 8'd0) begin
                    sp_s = sp_r - 8'd1;
                end else begin
                    ap_valid_s = 1'b1;
                    ap_data_s  = score_r[idx_r];
                    idx_s      = idx_r + 3'd1;
                    rem_s      = rem_r - 8'd1;
                    if (rem_r == 8'd1) begin
                        state_s = S_EXP_DRAIN;
                        sp_s    = ADD_END;
                    end else begin
                        sp_s = ADD_GAP;
                    end
                end
            end
            S_EXP_DRAIN: begin
                if (sp_r != 8'd0) begin
                    sp_s = sp_r - 8'd1;
                end else begin
                    state_s    = S_DIV;
                    ap_valid_s = 1'b1;
                    ap_data_s  = score_r[0];
                    ap_mode_s  = MODE_DIV;
                    idx_s      = 3'd1;
                    rem_s      = {5'd0, k_r};
                    sp_s       = (k_r == 3'd0) ? MUL_END : MUL_GAP;
                end
            end
            S_DIV: begin
                // rem_r counts divide beats still to issue; zero means draining.
                if (sp_r != 8'd0) begin
                    sp_s = sp_r - 8'd1;
                end else if (rem_r == 8'd0) begin
                    state_s = S_DONE;
                end else begin
                    ap_valid_s = 1'b1;
                    ap_data_s  = score_r[idx_r];
                    idx_s      = idx_r + 3'd1;
                    rem_s      = rem_r - 8'd1;
                    sp_s       = (rem_r == 8'd1) ? MUL_END : MUL_GAP;
                end
            end
            S_STREAM: begin
                if (!s_ready_r) begin
                    state_s = S_DONE;
                end else if (s_valid) begin
                    ap_valid_s = 1'b1;
                    ap_data_s  = s_data;
                    ap_psum_s  = (smode_r == MODE_AGG) ? s_psum : 16'd0;
                    ap_mode_s  = smode_r;
                    // Count 0 stands for 256, so only the 1 -> done step terminates.
                    if (rem_r == 8'd1) begin
                        s_ready_s = 1'b0;
                    end else begin
                        s_ready_s = 1'b1;
                        rem_s     = rem_r - 8'd1;
                    end
                end else begin
                    s_ready_s = 1'b1;
                end
            end
            S_DONE: begin
                state_s = S_IDLE;
            end
            default: begin
                state_s = S_IDLE;
            end
        endcase
    end

    // Sequencer state, counters and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= S_IDLE;
            sp_r       <= 8'd0;
            rem_r      <= 8'd0;
            idx_r      <= 3'd0;
            k_r        <= 3'd0;
            smode_r    <= 2'd0;
            ap_valid_r <= 1'b0;
            ap_data_r  <= 16'd0;
            ap_psum_r  <= 16'd0;
            ap_mode_r  <= 2'd0;
            s_ready_r  <= 1'b0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            err_r      <= 1'b0;
        end else begin
            state_r    <= state_s;
            sp_r       <= sp_s;
            rem_r      <= rem_s;
            idx_r      <= idx_s;
            k_r        <= k_s;
            smode_r    <= smode_s;
            ap_valid_r <= ap_valid_s;
            ap_data_r  <= ap_data_s;
            ap_psum_r  <= ap_psum_s;
            ap_mode_r  <= ap_mode_s;
            s_ready_r  <= s_ready_s;
            busy_r     <= (state_s != S_IDLE);
            done_r     <= (state_s == S_DONE);
            err_r      <= err_s;
        end
    end

    // Score buffer: writable only while idle so an operation sees stable scores.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 8; i++) begin
                score_r[i] <= 16'd0;
            end
        end else if (sc_wr_en && (state_r == S_IDLE)) begin
            score_r[sc_wr_idx] <= sc_wr_data;
        end
    end

    assign s_ready  = s_ready_r;
    assign ap_valid = ap_valid_r;
    assign ap_data  = ap_data_r;
    assign ap_psum  = ap_psum_r;
    assign ap_mode  = ap_mode_r;
    assign busy     = busy_r;
    assign done     = done_r;
    assign err      = err_r;

endmodule

// File: tb/tb_arith_sequencer.sv
// Randomized self-checking bench for arith_sequencer against a cycle-offset
// reference model built from the operation timing rules.
module tb_arith_sequencer;

    localparam int A = 3;
    localparam int M = 3;

    logic        clk, rst_n;
    logic        sc_wr_en;
    logic [2:0]  sc_wr_idx;
    logic [15:0] sc_wr_data;
    logic        op_start;
    logic [1:0]  op_type;
    logic [2:0]  op_km1;
    logic [7:0]  op_len;
    logic        s_valid, s_ready;
    logic [15:0] s_data, s_psum;
    logic        ap_valid;
    logic [15:0] ap_data, ap_psum;
    logic [1:0]  ap_mode;
    logic        busy, done, err;

    int n_checks = 0;
    int n_pass   = 0;

    logic [15:0] score_m [8];
    logic [15:0] last_d, last_p;
    logic [1:0]  last_m;

    typedef struct {
        int          off;
        logic [15:0] d;
        logic [1:0]  m;
    } beat_t;

    arith_sequencer #(.ADD_LAT(A), .MUL_LAT(M)) dut (
        .clk(clk), .rst_n(rst_n),
        .sc_wr_en(sc_wr_en), .sc_wr_idx(sc_wr_idx), .sc_wr_data(sc_wr_data),
        .op_start(op_start), .op_type(op_type), .op_km1(op_km1), .op_len(op_len),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_psum(s_psum),
        .ap_valid(ap_valid), .ap_data(ap_data), .ap_psum(ap_psum), .ap_mode(ap_mode),
        .busy(busy), .done(done), .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_ap_valid"}, {31'd0, ap_valid}, 32'd0);
        check({tag, "_ap_data"},  {16'd0, ap_data},  32'd0);
        check({tag, "_ap_psum"},  {16'd0, ap_psum},  32'd0);
        check({tag, "_ap_mode"},  {30'd0, ap_mode},  32'd0);
        check({tag, "_busy"},     {31'd0, busy},     32'd0);
        check({tag, "_done"},     {31'd0, done},     32'd0);
        check({tag, "_err"},      {31'd0, err},      32'd0);
        check({tag, "_s_ready"},  {31'd0, s_ready},  32'd0);
    endtask

    task automatic write_score(input logic [2:0] i, input logic [15:0] d);
        @(posedge clk); #1;
        sc_wr_en   = 1'b1;
        sc_wr_idx  = i;
        sc_wr_data = d;
        @(posedge clk); #1;
        sc_wr_en   = 1'b0;
        score_m[i] = d;
    endtask

    // vmode: 0 = s_valid held high, 1 = alternating 1,0,1,..., 2 = random
    task automatic run_op(input logic [1:0] typ, input logic [2:0] km1,
                          input logic [7:0] len, input int vmode);
        beat_t       q[$];
        beat_t       b;
        int          k, done_off, rem, last_exp, div0;
        bit          rdy_e, pend, busy_e, exp_v, finished;
        logic [15:0] pd, pp;
        logic [1:0]  smode;
        k        = int'(km1) + 1;
        done_off = -1;
        rdy_e    = 1'b0;
        pend     = 1'b0;
        finished = 1'b0;
        pd       = 16'd0;
        pp       = 16'd0;
        smode    = (typ == 2'd1) ? 2'd2 : 2'd3;
        rem      = 0;
        if (typ == 2'd0) begin
            for (int i = 0; i < k; i++) begin
                b.off = 1 + i * (A + 1); b.d = score_m[i]; b.m = 2'd0;
                q.push_back(b);
            end
            last_exp = 1 + (k - 1) * (A + 1);
            div0     = last_exp + A + 2;
            for (int i = 0; i < k; i++) begin
                b.off = div0 + i * (M + 1); b.d = score_m[i]; b.m = 2'd1;
                q.push_back(b);
            end
            done_off = div0 + (k - 1) * (M + 1) + M + 2;
        end else begin
            rem   = (typ == 2'd1) ? ((len == 8'd0) ? 256 : int'(len)) : k;
            rdy_e = 1'b1;
        end
        @(posedge clk); #1;
        op_start = 1'b1;
        op_type  = typ;
        op_km1   = km1;
        op_len   = len;
        for (int c = 1; c <= 2000; c++) begin
            @(posedge clk); #1;
            op_start = 1'b0;
            sc_wr_en = 1'b0;
            s_valid  = 1'b0;
            busy_e   = (done_off < 0) || (c <= done_off);
            // Requests and score writes while busy must leave the run untouched.
            if (busy_e && ($urandom_range(0, 3) == 0)) begin
                op_start   = 1'b1;
                op_type    = 2'($urandom_range(0, 3));
                sc_wr_en   = 1'b1;
                sc_wr_idx  = 3'($urandom_range(0, 7));
                sc_wr_data = 16'($urandom);
            end
            if (typ != 2'd0) begin
                if (vmode == 0)      s_valid = 1'b1;
                else if (vmode == 1) s_valid = c[0];
                else                 s_valid = 1'($urandom_range(0, 1));
                s_data = 16'($urandom);
                s_psum = 16'($urandom);
            end
            @(negedge clk);
            exp_v = 1'b0;
            if (typ == 2'd0) begin
                if (q.size() > 0 && q[0].off == c) begin
                    b = q.pop_front();
                    exp_v = 1'b1; last_d = b.d; last_p = 16'd0; last_m = b.m;
                end
            end else if (pend) begin
                exp_v = 1'b1; last_d = pd; last_p = pp; last_m = smode;
            end
            check("ap_valid", {31'd0, ap_valid}, {31'd0, exp_v});
            check("ap_data",  {16'd0, ap_data},  {16'd0, last_d});
            check("ap_psum",  {16'd0, ap_psum},  {16'd0, last_p});
            check("ap_mode",  {30'd0, ap_mode},  {30'd0, last_m});
            check("done",     {31'd0, done},     {31'd0, (c == done_off)});
            check("busy",     {31'd0, busy},     {31'd0, busy_e});
            check("err",      {31'd0, err},      32'd0);
            check("s_ready",  {31'd0, s_ready},  {31'd0, rdy_e});
            pend = 1'b0;
            if (typ != 2'd0 && s_valid && rdy_e) begin
                pend = 1'b1;
                pd   = s_data;
                pp   = (typ == 2'd2) ? s_psum : 16'd0;
                rem--;
                if (rem == 0) begin
                    rdy_e    = 1'b0;
                    done_off = c + 2;
                end
            end
            if (done_off >= 0 && c == done_off + 1) begin
                finished = 1'b1;
                break;
            end
        end
        s_valid  = 1'b0;
        op_start = 1'b0;
        sc_wr_en = 1'b0;
        check("op_timeout", {31'd0, finished}, 32'd1);
    endtask

    initial begin
        rst_n = 1'b0; sc_wr_en = 1'b0; sc_wr_idx = 3'd0; sc_wr_data = 16'd0;
        op_start = 1'b0; op_type = 2'd0; op_km1 = 3'd0; op_len = 8'd0;
        s_valid = 1'b0; s_data = 16'd0; s_psum = 16'd0;
        for (int i = 0; i < 8; i++) score_m[i] = 16'd0;
        last_d = 16'd0; last_p = 16'd0; last_m = 2'd0;
        #23 rst_n = 1'b1;
        @(negedge clk);
        check_all_zero("reset");

        // Softmax over three scores, then again to confirm busy writes were dropped.
        write_score(3'd0, 16'h3C00);
        write_score(3'd1, 16'h4000);
        write_score(3'd2, 16'h4200);
        run_op(2'd0, 3'd2, 8'd0, 0);
        run_op(2'd0, 3'd2, 8'd0, 0);

        run_op(2'd1, 3'd0, 8'd4, 0);
        run_op(2'd2, 3'd1, 8'd0, 1);

        // Reserved op type: single err pulse, never busy.
        @(posedge clk); #1;
        op_start = 1'b1; op_type = 2'd3;
        @(posedge clk); #1;
        op_start = 1'b0;
        @(negedge clk);
        check("err_pulse", {31'd0, err},  32'd1);
        check("err_busy",  {31'd0, busy}, 32'd0);
        @(negedge clk);
        check("err_clear", {31'd0, err},  32'd0);
        check("err_busy2", {31'd0, busy}, 32'd0);

        run_op(2'd0, 3'd0, 8'd0, 0);
        for (int i = 0; i < 8; i++) write_score(3'(i), 16'($urandom));
        run_op(2'd0, 3'd7, 8'd0, 0);
        run_op(2'd2, 3'd7, 8'd0, 2);
        run_op(2'd1, 3'd0, 8'd0, 0);

        for (int n = 0; n < 12; n++) begin
            write_score(3'($urandom_range(0, 7)), 16'($urandom));
            run_op(2'($urandom_range(0, 2)), 3'($urandom_range(0, 7)),
                   8'($urandom_range(1, 20)), 2);
        end

        // Reset in the middle of the divide phase aborts without a done pulse.
        write_score(3'd0, 16'h1111);
        @(posedge clk); #1;
        op_start = 1'b1; op_type = 2'd0; op_km1 = 3'd2;
        @(posedge clk); #1;
        op_start = 1'b0;
        repeat (15) @(posedge clk);
        #3 rst_n = 1'b0;
        #1 check_all_zero("midrst");
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        for (int i = 0; i < 8; i++) score_m[i] = 16'd0;
        last_d = 16'd0; last_p = 16'd0; last_m = 2'd0;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            check("post_rst_done", {31'd0, done}, 32'd0);
            check("post_rst_busy", {31'd0, busy}, 32'd0);
        end
        run_op(2'd0, 3'd1, 8'd0, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
